// File: rtl/uart_cmd_queue.sv
// ---------------------------------------------------------------------------
// uart_cmd_queue
//   Buffers bytes received from the UART so the CPU can consume them at its
//   own pace. The game keys U/D/L/R are decoded to codes 1..4. Other bytes are
//   dropped, or, with RAW_MODE = 1, every byte is stored unchanged. Accepted
//   entries go into a first-word-fall-through FIFO that the CPU pops through
//   the memory map. A one-hot LED register shows the last key received.
//
// Ports
//   clk       in   1        system clock (posedge)
//   rst       in   1        asynchronous active-high reset
//   rx_data   in   DATA_W   received byte, stable while rx_valid is high
//   rx_valid  in   1        receiver valid level (one accept per high period)
//   rd_en     in   1        pop request from the CPU
//   clr_ovf   in   1        clears the sticky overflow flag
//   rd_data   out  32       head entry, zero-extended; 0 while empty
//   empty     out  1        FIFO holds no entries
//   full      out  1        FIFO holds DEPTH entries
//   count     out  AW+1     number of stored entries, 0..DEPTH
//   overflow  out  1        sticky: a byte was dropped because FIFO was full
//   leds      out  LED_W    one-hot indication of the last key received
// ---------------------------------------------------------------------------
module uart_cmd_queue #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int LED_W    = 4,
  parameter int RAW_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_valid,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic [31:0]                rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [LED_W-1:0]           leds
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [DATA_W-1:0] K_UP    = DATA_W'(8'h55);
  localparam logic [DATA_W-1:0] K_DOWN  = DATA_W'(8'h44);
  localparam logic [DATA_W-1:0] K_LEFT  = DATA_W'(8'h4C);
  localparam logic [DATA_W-1:0] K_RIGHT = DATA_W'(8'h52);

  function automatic logic [2:0] f_decode(input logic [DATA_W-1:0] b);
    logic [2:0] code;
    code = 3'd0;
    if (b == K_UP)         code = 3'd1;
    else if (b == K_DOWN)  code = 3'd2;
    else if (b == K_LEFT)  code = 3'd3;
    else if (b == K_RIGHT) code = 3'd4;
    return code;
  endfunction

  // Bits above [3] stay 0 for any LED_W >= 4.
  function automatic logic [LED_W-1:0] f_onehot(input logic [2:0] code);
    logic [LED_W-1:0] v;
    v = '0;
    case (code)
      3'd1:    v = LED_W'(4'b0001);
      3'd2:    v = LED_W'(4'b0010);
      3'd3:    v = LED_W'(4'b0100);
      3'd4:    v = LED_W'(4'b1000);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_prev_valid;
  logic              r_ovf;
  logic [LED_W-1:0]  r_leds;

  logic              w_accept;
  logic [2:0]        w_code;
  logic [DATA_W-1:0] w_entry;
  logic              w_push_req;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign count    = r_count;
  assign overflow = r_ovf;
  assign leds     = r_leds;
  assign rd_data  = empty ? 32'd0 : 32'(r_mem[r_rd_ptr]);

  // Edge-detect the level valid so a long rx_valid pulse is taken once.
  assign w_accept   = rx_valid & ~r_prev_valid;
  assign w_code     = f_decode(rx_data);
  assign w_entry    = (RAW_MODE != 0) ? rx_data : DATA_W'(w_code);
  assign w_push_req = w_accept & ((RAW_MODE != 0) | (w_code != 3'd0));
  assign w_pop      = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push     = w_push_req & (~full | w_pop);
  assign w_drop     = w_push_req & full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_prev_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_leds       <= '0;
    end else begin
      r_prev_valid <= rx_valid;
      if (w_accept) r_leds <= f_onehot(w_code);
      if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A new drop outranks a clear in the same cycle.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_queue.sv
module tb_uart_cmd_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;

  logic [31:0] rd_data, r_rd_data;
  logic        empty, full, overflow, r_empty, r_full, r_overflow;
  logic [3:0]  count, r_count;
  logic [3:0]  leds, r_leds;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_cmd_queue #(.DATA_W(8), .DEPTH(8), .LED_W(4), .RAW_MODE(0)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .leds(leds)
  );

  uart_cmd_queue #(.DATA_W(8), .DEPTH(8), .LED_W(4), .RAW_MODE(1)) u_raw (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(r_rd_data), .empty(r_empty),
    .full(r_full), .count(r_count), .overflow(r_overflow), .leds(r_leds)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a byte with rx_valid high for n rising edges, then one idle cycle.
  task automatic send(input logic [7:0] b, input int n);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (n) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop1();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_leds", leds, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    // Long valid pulse is accepted exactly once
    send(8'h55, 3);
    chk("u_count", count, 1);
    chk("u_rd_data", rd_data, 1);
    chk("u_leds", leds, 4'b0001);
    chk("u_empty", empty, 0);

    // Three more keys, then drain in order
    send(8'h44, 1);
    chk("d_leds", leds, 4'b0010);
    send(8'h4C, 1);
    chk("l_leds", leds, 4'b0100);
    send(8'h52, 1);
    chk("r_leds", leds, 4'b1000);
    chk("four_count", count, 4);
    chk("pop_head1", rd_data, 1);
    pop1();
    chk("pop_head2", rd_data, 2);
    pop1();
    chk("pop_head3", rd_data, 3);
    pop1();
    chk("pop_head4", rd_data, 4);
    pop1();
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // Non-key byte: dropped when decoding, stored raw otherwise
    send(8'h41, 1);
    chk("a_count", count, 0);
    chk("a_empty", empty, 1);
    chk("a_leds", leds, 4'b0000);
    chk("a_rd_data", rd_data, 0);
    chk("raw_rd_data", r_rd_data, 32'h41);
    chk("raw_count", r_count, 1);

    // Fill from a clean state and overflow with the ninth key
    do_reset();
    send(8'h55, 1); send(8'h44, 1); send(8'h4C, 1); send(8'h52, 1);
    send(8'h55, 1); send(8'h44, 1); send(8'h4C, 1); send(8'h52, 1);
    chk("fill_full", full, 1);
    chk("fill_ovf_pre", overflow, 0);
    send(8'h55, 1);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", rd_data, 1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    // Pop and push on the same edge while full
    @(negedge clk);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    rd_en    = 1'b1;
    @(negedge clk);
    rd_en    = 1'b0;
    rx_valid = 1'b0;
    chk("pp_count", count, 8);
    chk("pp_full", full, 1);
    chk("pp_ovf", overflow, 0);
    chk("pp_wr_ptr", dut.r_wr_ptr, 1);
    chk("pp_head", rd_data, 2);
    repeat (6) pop1();
    chk("pp_seventh", rd_data, 4);
    pop1();
    chk("pp_last", rd_data, 1);
    chk("pp_last_count", count, 1);
    pop1();
    chk("pp_drained", empty, 1);

    // Asynchronous reset with entries queued
    send(8'h44, 1); send(8'h4C, 1); send(8'h52, 1);
    chk("pre_rst_count", count, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_count", count, 0);
    chk("arst_leds", leds, 0);
    // Hold a key through reset: taken once after release
    rx_data  = 8'h52;
    rx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_count", count, 1);
    chk("held_head", rd_data, 4);
    rx_valid = 1'b0;
    pop1();
    chk("held_popped", empty, 1);

    // Pop request while empty is ignored
    pop1();
    chk("empty_rd_count", count, 0);
    chk("empty_rd_empty", empty, 1);
    chk("empty_rd_data", rd_data, 0);
    send(8'h4C, 1);
    chk("after_empty_rd_head", rd_data, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
